// File: rtl/tick_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_monitor_if : strobe-under-test and health status bundle.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface tick_monitor_if #(
  parameter int CNT_W = 16
);
  logic             en_in;
  logic             clear_err;
  logic             locked;
  logic             early;
  logic             late;
  logic             err_sticky;
  logic [7:0]       err_count;
  logic [CNT_W-1:0] last_period;

  modport master (
    output en_in, clear_err,
    input  locked, early, late, err_sticky, err_count, last_period
  );

  modport slave (
    input  en_in, clear_err,
    output locked, early, late, err_sticky, err_count, last_period
  );
endinterface
`default_nettype wire

// File: rtl/tick_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_monitor : measures strobe intervals, locks after LOCK_N good    |
// | intervals, flags early/late strobes while locked. Rev 1.0            |
// +----------------------------------------------------------------------+
module tick_monitor #(
  parameter int PERIOD = 10001,
  parameter int TOL    = 2,
  parameter int LOCK_N = 4,
  parameter int CNT_W  = 16
) (
  input  wire            mclk,
  input  wire            reset,
  tick_monitor_if.slave  bus
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]  c_win_hi   = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0]  c_win_lo   = CNT_W'(PERIOD - TOL);
  localparam logic [GOOD_W-1:0] c_good_top = GOOD_W'(LOCK_N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic             locked_q, locked_d;
  logic             early_q, early_d;
  logic             late_q, late_d;
  logic             sticky_q, sticky_d;
  logic [7:0]       count_q, count_d;

  logic             w_err_ev;
  logic             w_in_win;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;

  // Upper bound needs no test: a timeout always precedes any longer interval.
  assign w_in_win  = (cnt_q >= c_win_lo);
  assign w_timeout = (cnt_q == c_win_hi);
  assign w_cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = w_cnt_inc;
    good_d   = good_q;
    last_d   = last_q;
    early_d  = 1'b0;
    late_d   = 1'b0;
    w_err_ev = 1'b0;
    sticky_d = sticky_q;
    count_d  = count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.en_in) begin
          cnt_d   = CNT_W'(1);
          good_d  = '0;
          state_d = S_ACQ;
        end
      end
      S_ACQ: begin
        if (bus.en_in) begin
          cnt_d  = CNT_W'(1);
          last_d = cnt_q;
          if (w_in_win) begin
            good_d = good_q + GOOD_W'(1);
            if (good_q == c_good_top) state_d = S_LOCK;
          end else begin
            good_d = '0;
          end
        end else if (w_timeout) begin
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        if (bus.en_in) begin
          cnt_d  = CNT_W'(1);
          last_d = cnt_q;
          if (!w_in_win) begin
            early_d  = 1'b1;
            w_err_ev = 1'b1;
            good_d   = '0;
            state_d  = S_ACQ;
          end
        end else if (w_timeout) begin
          late_d   = 1'b1;
          w_err_ev = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear is applied before a coincident error so the new event survives.
    if (bus.clear_err) begin
      sticky_d = 1'b0;
      count_d  = 8'd0;
    end
    if (w_err_ev) begin
      sticky_d = 1'b1;
      if (count_d != 8'hFF) count_d = count_d + 8'd1;
    end

    locked_d = (state_d == S_LOCK);
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      last_q   <= '0;
      locked_q <= 1'b0;
      early_q  <= 1'b0;
      late_q   <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      last_q   <= last_d;
      locked_q <= locked_d;
      early_q  <= early_d;
      late_q   <= late_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.early       = early_q;
  assign bus.late        = late_q;
  assign bus.err_sticky  = sticky_q;
  assign bus.err_count   = count_q;
  assign bus.last_period = last_q;

endmodule
`default_nettype wire

// File: tb/tb_tick_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tick_monitor : directed bench with a timestamp-based reference    |
// | model compared every cycle. Rev 1.0                                  |
// +----------------------------------------------------------------------+
module tb_tick_monitor;
  localparam int PERIOD = 10;
  localparam int TOL    = 1;
  localparam int LOCK_N = 3;
  localparam int CNT_W  = 8;

  logic mclk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  tick_monitor_if #(.CNT_W(CNT_W)) bus ();

  tick_monitor #(.PERIOD(PERIOD), .TOL(TOL), .LOCK_N(LOCK_N), .CNT_W(CNT_W)) dut (
    .mclk  (mclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the edge number of the last reference strobe.
  int  edge_n = 0;
  int  ref_t;
  int  iv;
  bit  have_ref, started;
  int  good;
  int  m_locked, m_early, m_late, m_sticky, m_cnt, m_last;
  bit  err_ev;

  always @(posedge mclk) begin
    edge_n++;
    m_early = 0;
    m_late  = 0;
    err_ev  = 0;
    if (reset) begin
      started  = 1;
      have_ref = 0;
      good     = 0;
      m_locked = 0;
      m_sticky = 0;
      m_cnt    = 0;
      m_last   = 0;
    end else begin
      if (bus.en_in) begin
        if (!have_ref) begin
          have_ref = 1;
          ref_t    = edge_n;
          good     = 0;
        end else begin
          iv     = edge_n - ref_t;
          ref_t  = edge_n;
          m_last = iv;
          if (iv >= PERIOD - TOL && iv <= PERIOD + TOL) begin
            if (!m_locked) begin
              good++;
              if (good == LOCK_N) m_locked = 1;
            end
          end else begin
            if (m_locked) begin
              m_early  = 1;
              err_ev   = 1;
              m_locked = 0;
            end
            good = 0;
          end
        end
      end else if (have_ref && (edge_n - ref_t) == PERIOD + TOL) begin
        if (m_locked) begin
          m_late = 1;
          err_ev = 1;
        end
        have_ref = 0;
        m_locked = 0;
      end
      if (bus.clear_err) begin
        m_cnt    = 0;
        m_sticky = 0;
      end
      if (err_ev) begin
        m_sticky = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end

  always @(negedge mclk) begin
    if (started) begin
      chk("locked",      int'(bus.locked),      m_locked);
      chk("early",       int'(bus.early),       m_early);
      chk("late",        int'(bus.late),        m_late);
      chk("err_sticky",  int'(bus.err_sticky),  m_sticky);
      chk("err_count",   int'(bus.err_count),   m_cnt);
      chk("last_period", int'(bus.last_period), m_last);
    end
  end

  task automatic cyc(input bit en, input bit clr);
    bus.en_in     = en;
    bus.clear_err = clr;
    @(posedge mclk);
    #1;
    bus.en_in     = 1'b0;
    bus.clear_err = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  // Strobe n edges after the previous strobe.
  task automatic strobe_after(input int n, input bit clr = 1'b0);
    idle(n - 1);
    cyc(1'b1, clr);
  endtask

  initial begin
    reset         = 1'b1;
    bus.en_in     = 1'b1;
    bus.clear_err = 1'b0;
    @(posedge mclk);
    #1;
    cyc(1'b1, 1'b0);
    reset = 1'b0;
    chk("rst_locked", int'(bus.locked), 0);
    chk("rst_count",  int'(bus.err_count), 0);
    chk("rst_last",   int'(bus.last_period), 0);
    idle(3);

    // Nominal lock
    cyc(1'b1, 1'b0);
    chk("first_ref_last", int'(bus.last_period), 0);
    strobe_after(10);
    strobe_after(10);
    chk("pre_lock", int'(bus.locked), 0);
    strobe_after(10);
    chk("nom_locked", int'(bus.locked), 1);
    chk("nom_last",   int'(bus.last_period), 10);
    chk("nom_count",  int'(bus.err_count), 0);

    // Early while locked
    strobe_after(8);
    chk("early_pulse",  int'(bus.early), 1);
    chk("early_locked", int'(bus.locked), 0);
    chk("early_count",  int'(bus.err_count), 1);
    chk("early_sticky", int'(bus.err_sticky), 1);
    chk("early_last",   int'(bus.last_period), 8);
    cyc(1'b0, 1'b0);
    chk("early_one_cycle", int'(bus.early), 0);
    strobe_after(9);
    strobe_after(10);
    strobe_after(10);
    chk("relock", int'(bus.locked), 1);

    // Late while locked
    idle(10);
    chk("late_not_yet", int'(bus.late), 0);
    chk("late_still_locked", int'(bus.locked), 1);
    cyc(1'b0, 1'b0);
    chk("late_pulse",  int'(bus.late), 1);
    chk("late_locked", int'(bus.locked), 0);
    chk("late_count",  int'(bus.err_count), 2);
    cyc(1'b0, 1'b0);
    chk("late_one_cycle", int'(bus.late), 0);
    cyc(1'b1, 1'b0);
    chk("idle_ref_last", int'(bus.last_period), 10);

    // Window edges with an ACQ early
    strobe_after(9);
    strobe_after(8);
    chk("acq_early_no_pulse", int'(bus.early), 0);
    chk("acq_early_count",    int'(bus.err_count), 2);
    chk("acq_early_last",     int'(bus.last_period), 8);
    strobe_after(9);
    strobe_after(11);
    chk("win_pre_lock", int'(bus.locked), 0);
    strobe_after(9);
    chk("win_locked", int'(bus.locked), 1);
    chk("win_count",  int'(bus.err_count), 2);

    // Saturating count
    for (int k = 0; k < 256; k++) begin
      strobe_after(5);
      strobe_after(10);
      strobe_after(10);
      strobe_after(10);
    end
    chk("sat_count",  int'(bus.err_count), 255);
    chk("sat_sticky", int'(bus.err_sticky), 1);
    chk("sat_locked", int'(bus.locked), 1);
    strobe_after(10, 1'b1);
    chk("clr_count",  int'(bus.err_count), 0);
    chk("clr_sticky", int'(bus.err_sticky), 0);
    strobe_after(4);
    strobe_after(10);
    strobe_after(10);
    strobe_after(10);
    chk("pre_clr_err_count", int'(bus.err_count), 1);
    strobe_after(6, 1'b1);
    chk("clr_err_count",  int'(bus.err_count), 1);
    chk("clr_err_sticky", int'(bus.err_sticky), 1);
    strobe_after(10);
    strobe_after(10);
    strobe_after(10);
    chk("pre_rst_locked", int'(bus.locked), 1);

    // Reset mid-lock with en_in high
    idle(3);
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    reset = 1'b0;
    chk("mid_rst_locked", int'(bus.locked), 0);
    chk("mid_rst_count",  int'(bus.err_count), 0);
    chk("mid_rst_sticky", int'(bus.err_sticky), 0);
    chk("mid_rst_last",   int'(bus.last_period), 0);
    idle(4);
    cyc(1'b1, 1'b0);
    chk("post_rst_ref_last", int'(bus.last_period), 0);
    strobe_after(10);
    strobe_after(10);
    strobe_after(10);
    chk("post_rst_locked", int'(bus.locked), 1);
    chk("post_rst_last",   int'(bus.last_period), 10);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tick_monitor.md
# tick_monitor

Checks the periodic one-cycle enable strobe produced by the design's 1 s/RCO prescalers. It measures the interval between strobes and declares lock after a run of in-tolerance intervals. Early or missing strobes are flagged as error pulses, a sticky flag and a saturating count. It sits downstream of a prescaler, as a health monitor for logic that uses the strobe as its clock enable.

## Interface
- PERIOD, 10001: nominal strobe interval in mclk cycles; a strobe every PERIOD cycles is nominal.
- TOL, 2: allowed deviation in cycles; PERIOD-TOL ≤ interval ≤ PERIOD+TOL is in window. Require TOL < PERIOD-1.
- LOCK_N, 4: consecutive in-window intervals required to lock (≥1).
- CNT_W, 16: interval counter width; must hold PERIOD+TOL.
- mclk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- en_in  in  1  strobe under test, sampled each mclk edge; every high cycle counts as a strobe.
- clear_err  in  1  clears err_sticky and err_count.
- locked  out  1  high while in LOCK state.
- early  out  1  one-cycle pulse: strobe arrived below window while locked.
- late  out  1  one-cycle pulse: window expired without a strobe while locked.
- err_sticky  out  1  set by early/late, cleared by clear_err.
- err_count  out  8  early+late events, saturates at 255.
- last_period  out  CNT_W  most recently measured interval.

## Operation
- Interval counter cnt, CNT_W bits, saturating. On a strobe edge the measured interval is the current cnt, and cnt is loaded with 1. Otherwise cnt increments. A strobe at edge t and the next at t+P give interval P.
- States:
  - IDLE: no reference strobe. The first strobe loads cnt=1, sets good=0 and goes to ACQ. last_period is not updated.
  - ACQ:
    - In-window strobe: good+1; when good reaches LOCK_N, go to LOCK.
    - Early strobe (interval < PERIOD-TOL): good=0, stay in ACQ, no error.
    - Timeout (no strobe and cnt == PERIOD+TOL): go to IDLE, no error.
  - LOCK:
    - In-window strobe: stay.
    - Early strobe: early pulse, error event, good=0, go to ACQ. The strobe becomes the new reference.
    - Timeout: late pulse, error event, go to IDLE.
- A strobe exactly at cnt == PERIOD+TOL is in window. Timeout and strobe cannot coincide; the strobe wins.
- last_period is updated on every strobe in ACQ or LOCK, including early ones.
- Error event: err_sticky=1 and err_count+1, saturating at 255.
- If clear_err and an error event occur on the same edge, clear is applied first: err_sticky=1, err_count=1.
- If clear_err occurs alone: both are cleared.
- Errors are never counted outside LOCK.

## Timing
- All outputs are registered. Reset values: locked=0, early=0, late=0, err_sticky=0, err_count=0, last_period=0; internally state=IDLE, cnt=0, good=0.
- Reset is synchronous and overrides all inputs, including en_in on the same edge. Reset mid-LOCK gives locked=0 after that edge and discards the count.
- Latency 1: an event sampled at edge k is visible after edge k. This covers locked rise/fall, early, late, err_count, err_sticky and last_period.
- early and late are high exactly one cycle per event.
- Timeout edge: PERIOD+TOL edges after the last strobe edge.
- Back-to-back strobes (en_in held high) measure interval 1, which is early.

## Test plan
Bench parameters for all scenarios: PERIOD=10, TOL=1, LOCK_N=3, CNT_W=8.
- Nominal lock: strobes every 10 cycles -> locked=1 after the 4th strobe edge, last_period=10, no early/late, err_count=0.
- Early while locked: after lock, next strobe at interval 8 -> early for one cycle, err_count=1, err_sticky=1, locked=0, last_period=8. Three further 10-cycle intervals -> locked=1 again.
- Late while locked: after lock, strobes stop -> late pulse following the edge 11 cycles after the last strobe, locked=0, state IDLE, err_count=1. The next strobe alone does not update last_period.
- Window edges: intervals 9, 11, 9 from IDLE -> lock with no errors. In ACQ, an interval of 8 resets good: lock needs 3 more good intervals, err_count unchanged.
- Counter and clear: force 256 early events -> err_count=255 (saturated). clear_err alone -> 0 and err_sticky=0. clear_err on the same edge as an early event -> err_count=1, err_sticky=1.
- Reset mid-operation: reset asserted for one edge while locked and en_in=1 -> all outputs 0. A following strobe is treated as the first reference, and 3 good intervals re-lock.
